axi_burst_wr_master: RTL and testbench

AXI_BURST_WR_MASTER -- requirements
Module: axi_burst_wr_master

---
 rtl/axi_pkg.sv | 29 ++
 rtl/axi_burst_wr_master_if.sv | 37 +++
 rtl/axi_rst_sync.sv | 19 +
 rtl/axi_burst_wr_master.sv | 151 +++++++++++++++
 tb/tb_axi_burst_wr_master.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_pkg.sv
// Shared AXI encodings, FSM state type and helpers for the burst write master.
package axi_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } e_resp;

    typedef enum logic [1:0] {
        FIXED = 2'b00,
        INCR  = 2'b01,
        WRAP  = 2'b10
    } e_burst;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ADDR = 2'b01,
        DATA = 2'b10,
        RESP = 2'b11
    } e_state;

    // AxSIZE encoding for a full-width beat
    function automatic logic [2:0] size_enc(input int unsigned data_w);
        return 3'($clog2(data_w / 8));
    endfunction

endpackage

// File: rtl/axi_burst_wr_master_if.sv
// AXI4 write-channel bundle (AW, W, B) with master and slave views.
interface axi_burst_wr_master_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LEN_W  = 8
);
    logic                  AWVALID;
    logic                  AWREADY;
    logic [ADDR_W-1:0]     AWADDR;
    logic [LEN_W-1:0]      AWLEN;
    logic [2:0]            AWSIZE;
    logic [1:0]            AWBURST;

    logic                  WVALID;
    logic                  WREADY;
    logic [DATA_W-1:0]     WDATA;
    logic [DATA_W/8-1:0]   WSTRB;
    logic                  WLAST;

    logic                  BVALID;
    logic                  BREADY;
    logic [1:0]            BRESP;

    modport master (
        output AWVALID, AWADDR, AWLEN, AWSIZE, AWBURST,
        output WVALID, WDATA, WSTRB, WLAST,
        output BREADY,
        input  AWREADY, WREADY, BVALID, BRESP
    );

    modport slave (
        input  AWVALID, AWADDR, AWLEN, AWSIZE, AWBURST,
        input  WVALID, WDATA, WSTRB, WLAST,
        input  BREADY,
        output AWREADY, WREADY, BVALID, BRESP
    );
endinterface

// File: rtl/axi_rst_sync.sv
// Two-flop reset synchroniser: asserts asynchronously, releases on clk.
module axi_rst_sync (
    input  logic clk,
    input  logic arst_n,
    output logic rst_n
);
    logic meta;

    // Shift a one through two flops after arst_n releases
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            meta  <= 1'b0;
            rst_n <= 1'b0;
        end else begin
            meta  <= 1'b1;
            rst_n <= meta;
        end
    end
endmodule

// File: rtl/axi_burst_wr_master.sv
// Single-outstanding AXI4 INCR burst write master fed by a command port and
// a valid/ready data stream. Optional B-channel timeout: AXI_WR_TIMEOUT_EN.
module axi_burst_wr_master
    import axi_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned LEN_W       = 8,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic                ACLK,
    input  logic                ARESETn,

    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [LEN_W-1:0]    cmd_len,

    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [DATA_W-1:0]   wr_data,

    output logic                done,
    output logic [1:0]          done_resp,
    output logic                busy,

    axi_burst_wr_master_if.master axi
);

    if (!(DATA_W == 8 || DATA_W == 16 || DATA_W == 32 || DATA_W == 64)) begin : g_bad_data_w
        $error("DATA_W must be 8, 16, 32 or 64");
    end

    logic              rst_n;
    e_state            state;
    e_state            state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  beat_cnt;
    logic              ready_q;
    logic              done_q;
    logic [1:0]        resp_q;
    logic              cmd_fire;
    logic              w_fire;
    logic              last_beat;
    logic              timeout_hit;

    axi_rst_sync u_rst_sync (
        .clk    (ACLK),
        .arst_n (ARESETn),
        .rst_n  (rst_n)
    );

    // done blocks acceptance so a new command lands no earlier than the cycle after it
    assign cmd_fire  = (state == IDLE) && ready_q && !done_q && cmd_valid;
    assign w_fire    = (state == DATA) && wr_valid && axi.WREADY;
    assign last_beat = (state == DATA) && (beat_cnt == len_q);

    // State register
    always_ff @(posedge ACLK or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_fire)                         state_nxt = ADDR;
            ADDR:    if (axi.AWREADY)                      state_nxt = DATA;
            DATA:    if (w_fire && last_beat)              state_nxt = RESP;
            RESP:    if (axi.BVALID || timeout_hit)        state_nxt = IDLE;
            default:                                       state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from registered state; W channel passes the stream through
    always_comb begin
        cmd_ready   = 1'b0;
        busy        = 1'b0;
        wr_ready    = 1'b0;
        axi.AWVALID = 1'b0;
        axi.WVALID  = 1'b0;
        axi.WLAST   = 1'b0;
        axi.BREADY  = 1'b0;
        axi.AWADDR  = addr_q;
        axi.AWLEN   = len_q;
        axi.AWSIZE  = size_enc(DATA_W);
        axi.AWBURST = 2'(INCR);
        axi.WDATA   = wr_data;
        axi.WSTRB   = '1;

        cmd_ready   = (state == IDLE) && ready_q && !done_q;
        busy        = (state != IDLE);
        axi.AWVALID = (state == ADDR);
        axi.WVALID  = (state == DATA) && wr_valid;
        wr_ready    = (state == DATA) && axi.WREADY;
        axi.WLAST   = last_beat;
        axi.BREADY  = (state == RESP);
    end

    // Command capture, beat counting and completion status
    always_ff @(posedge ACLK or negedge rst_n) begin
        if (!rst_n) begin
            addr_q   <= '0;
            len_q    <= '0;
            beat_cnt <= '0;
            ready_q  <= 1'b0;
            done_q   <= 1'b0;
            resp_q   <= 2'(OKAY);
        end else begin
            ready_q <= 1'b1;
            done_q  <= (state == RESP) && (axi.BVALID || timeout_hit);
            if (cmd_fire) begin
                addr_q   <= cmd_addr;
                len_q    <= cmd_len;
                beat_cnt <= '0;
            end else if (w_fire && !last_beat) begin
                beat_cnt <= LEN_W'(beat_cnt + 1'b1);
            end
            if ((state == RESP) && axi.BVALID) begin
                resp_q <= axi.BRESP;
            end else if (timeout_hit) begin
                resp_q <= 2'(SLVERR);
            end
        end
    end

    assign done      = done_q;
    assign done_resp = resp_q;

`ifdef AXI_WR_TIMEOUT_EN
    localparam int unsigned TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [TO_W-1:0] to_cnt;

    // Count RESP cycles spent waiting for BVALID
    always_ff @(posedge ACLK or negedge rst_n) begin
        if (!rst_n)               to_cnt <= '0;
        else if (state != RESP)   to_cnt <= '0;
        else if (!axi.BVALID)     to_cnt <= TO_W'(to_cnt + 1'b1);
    end

    assign timeout_hit = (state == RESP) && !axi.BVALID && (to_cnt == TO_W'(TIMEOUT_CYC - 1));
`else
    logic [31:0] timeout_unused;
    assign timeout_unused = 32'(TIMEOUT_CYC);
    assign timeout_hit    = 1'b0;
`endif

endmodule

// File: tb/tb_axi_burst_wr_master.sv
// Directed bench for axi_burst_wr_master with a scripted AXI slave.
module tb_axi_burst_wr_master;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned LW = 8;

    logic        clk = 1'b0;
    logic        ARESETn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_addr = '0;
    logic [7:0]  cmd_len = '0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [31:0] wr_data = '0;
    logic        done;
    logic [1:0]  done_resp;
    logic        busy;

    axi_burst_wr_master_if #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) axi_s ();

    axi_burst_wr_master #(
        .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .TIMEOUT_CYC(16)
    ) dut (
        .ACLK      (clk),
        .ARESETn   (ARESETn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .done      (done),
        .done_resp (done_resp),
        .busy      (busy),
        .axi       (axi_s)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    logic [31:0] wq[$];
    logic        lq[$];
    int          done_cnt = 0;
    logic [1:0]  last_resp = 2'b00;
    int          early_w = 0;
    int          ready_in_done = 0;
    bit          aw_hs = 1'b0;

    // Record W beats, done pulses and W-before-AW occurrences
    always @(posedge clk) begin
        if (!ARESETn) aw_hs = 1'b0;
        if (axi_s.WVALID && !aw_hs) early_w++;
        if (axi_s.WVALID && axi_s.WREADY) begin
            wq.push_back(axi_s.WDATA);
            lq.push_back(axi_s.WLAST);
        end
        if (axi_s.AWVALID && axi_s.AWREADY) aw_hs = 1'b1;
        if (done) begin
            done_cnt++;
            last_resp = done_resp;
            aw_hs = 1'b0;
            if (cmd_ready) ready_in_done++;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cmd_valid     = 1'b0;
        wr_valid      = 1'b0;
        axi_s.AWREADY = 1'b0;
        axi_s.WREADY  = 1'b0;
        axi_s.BVALID  = 1'b0;
        axi_s.BRESP   = 2'b00;
    endtask

    task automatic issue_cmd(input logic [31:0] addr, input logic [7:0] len);
        bit acc;
        acc = 1'b0;
        cmd_valid = 1'b1;
        cmd_addr  = addr;
        cmd_len   = len;
        for (int i = 0; i < 10 && !acc; i++) begin
            @(negedge clk);
            acc = cmd_ready;
            cyc();
        end
        cmd_valid = 1'b0;
        total++;
        if (!acc) begin bad++; $display("FAIL cmd_accept: cmd_ready never high for addr %h", addr); end
    endtask

    task automatic run_burst(input logic [31:0] addr, input logic [7:0] len, input int aw_delay,
                             input bit w_toggle, input bit v_gaps, input int b_delay,
                             input logic [1:0] bresp, input bit b_never,
                             output bit finished, output int resp_cycles);
        int beat;
        int aw_cnt;
        int start_done;
        bit fire;
        beat = 0; aw_cnt = 0; resp_cycles = 0; start_done = done_cnt; finished = 1'b0;
        for (int c = 0; c < 300 && !finished; c++) begin
            axi_s.AWREADY = (aw_cnt >= aw_delay);
            wr_valid      = (beat <= int'(len)) && !(v_gaps && (c % 3 == 1));
            wr_data       = {addr[15:0], 16'(beat)};
            axi_s.WREADY  = !(w_toggle && (c % 2 == 1));
            axi_s.BVALID  = !b_never && axi_s.BREADY && (resp_cycles >= b_delay);
            axi_s.BRESP   = bresp;
            @(negedge clk);
            fire = wr_valid && wr_ready;
            if (axi_s.AWVALID) aw_cnt++;
            if (axi_s.BREADY)  resp_cycles++;
            cyc();
            if (fire) beat++;
            if (done_cnt != start_done) finished = 1'b1;
        end
        idle_inputs();
    endtask

    task automatic test_reset();
        bit seen;
        idle_inputs();
        ARESETn = 1'b0;
        repeat (3) cyc();
        @(negedge clk);
        total++; if (axi_s.AWVALID !== 1'b0) begin bad++; $display("FAIL rst_awvalid: got %b want 0", axi_s.AWVALID); end
        total++; if (axi_s.WVALID !== 1'b0) begin bad++; $display("FAIL rst_wvalid: got %b want 0", axi_s.WVALID); end
        total++; if (axi_s.WLAST !== 1'b0) begin bad++; $display("FAIL rst_wlast: got %b want 0", axi_s.WLAST); end
        total++; if (axi_s.BREADY !== 1'b0) begin bad++; $display("FAIL rst_bready: got %b want 0", axi_s.BREADY); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", done); end
        total++; if (done_resp !== 2'b00) begin bad++; $display("FAIL rst_done_resp: got %b want 00", done_resp); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL rst_cmd_ready: got %b want 0", cmd_ready); end
        total++; if (axi_s.AWADDR !== 32'h0) begin bad++; $display("FAIL rst_awaddr: got %h want 0", axi_s.AWADDR); end
        total++; if (axi_s.AWLEN !== 8'h0) begin bad++; $display("FAIL rst_awlen: got %h want 0", axi_s.AWLEN); end
        cyc();
        ARESETn = 1'b1;
        @(negedge clk);
        total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL rel_cmd_ready: got %b want 0", cmd_ready); end
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            cyc();
            @(negedge clk);
            seen = cmd_ready;
        end
        total++; if (!seen) begin bad++; $display("FAIL rel_ready_timeout: cmd_ready %b want 1", cmd_ready); end
        cyc();
    endtask

    task automatic test_basic();
        bit fin; int rc; int d0;
        wq.delete(); lq.delete(); d0 = done_cnt;
        issue_cmd(32'h0000_1000, 8'd3);
        run_burst(32'h0000_1000, 8'd3, 0, 1'b0, 1'b0, 0, 2'b00, 1'b0, fin, rc);
        total++; if (fin !== 1'b1) begin bad++; $display("FAIL basic_done_seen: got %b want 1", fin); end
        total++; if (axi_s.AWADDR !== 32'h1000) begin bad++; $display("FAIL basic_awaddr: got %h want 1000", axi_s.AWADDR); end
        total++; if (axi_s.AWLEN !== 8'd3) begin bad++; $display("FAIL basic_awlen: got %0d want 3", axi_s.AWLEN); end
        total++; if (axi_s.AWBURST !== 2'b01) begin bad++; $display("FAIL basic_awburst: got %b want 01", axi_s.AWBURST); end
        total++; if (axi_s.AWSIZE !== 3'd2) begin bad++; $display("FAIL basic_awsize: got %0d want 2", axi_s.AWSIZE); end
        total++; if (axi_s.WSTRB !== 4'hF) begin bad++; $display("FAIL basic_wstrb: got %h want f", axi_s.WSTRB); end
        total++; if (wq.size() != 4) begin bad++; $display("FAIL basic_beats: got %0d want 4", wq.size()); end
        else begin
            for (int i = 0; i < 4; i++) begin
                total++; if (wq[i] !== 32'h1000_0000 + 32'(i)) begin bad++; $display("FAIL basic_data%0d: got %h want %h", i, wq[i], 32'h1000_0000 + 32'(i)); end
                total++; if (lq[i] !== (i == 3)) begin bad++; $display("FAIL basic_wlast%0d: got %b want %b", i, lq[i], (i == 3)); end
            end
        end
        total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL basic_done_count: got %0d want 1", done_cnt - d0); end
        total++; if (last_resp !== 2'b00) begin bad++; $display("FAIL basic_resp: got %b want 00", last_resp); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_after: got %b want 0", busy); end
    endtask

    task automatic test_single();
        bit fin; int rc; int d0;
        wq.delete(); lq.delete(); d0 = done_cnt;
        issue_cmd(32'h0000_2000, 8'd0);
        run_burst(32'h0000_2000, 8'd0, 0, 1'b0, 1'b0, 1, 2'b00, 1'b0, fin, rc);
        total++; if (fin !== 1'b1) begin bad++; $display("FAIL single_done_seen: got %b want 1", fin); end
        total++; if (wq.size() != 1) begin bad++; $display("FAIL single_beats: got %0d want 1", wq.size()); end
        else begin
            total++; if (wq[0] !== 32'h2000_0000) begin bad++; $display("FAIL single_data: got %h want 20000000", wq[0]); end
            total++; if (lq[0] !== 1'b1) begin bad++; $display("FAIL single_wlast: got %b want 1", lq[0]); end
        end
        total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL single_done_count: got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_stalls();
        bit fin; int rc; int d0;
        wq.delete(); lq.delete(); d0 = done_cnt;
        issue_cmd(32'h0000_3000, 8'd7);
        run_burst(32'h0000_3000, 8'd7, 2, 1'b1, 1'b1, 3, 2'b01, 1'b0, fin, rc);
        total++; if (fin !== 1'b1) begin bad++; $display("FAIL stall_done_seen: got %b want 1", fin); end
        total++; if (wq.size() != 8) begin bad++; $display("FAIL stall_beats: got %0d want 8", wq.size()); end
        else begin
            for (int i = 0; i < 8; i++) begin
                total++; if (wq[i] !== 32'h3000_0000 + 32'(i)) begin bad++; $display("FAIL stall_data%0d: got %h want %h", i, wq[i], 32'h3000_0000 + 32'(i)); end
                total++; if (lq[i] !== (i == 7)) begin bad++; $display("FAIL stall_wlast%0d: got %b want %b", i, lq[i], (i == 7)); end
            end
        end
        total++; if (last_resp !== 2'b01) begin bad++; $display("FAIL stall_resp: got %b want 01", last_resp); end
        total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL stall_done_count: got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_aw_stall();
        bit fin; int rc;
        wq.delete(); lq.delete();
        issue_cmd(32'h0000_4440, 8'd1);
        axi_s.AWREADY = 1'b0;
        axi_s.WREADY  = 1'b1;
        wr_valid      = 1'b1;
        wr_data       = 32'h4440_0000;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++; if (axi_s.AWVALID !== 1'b1) begin bad++; $display("FAIL awstall_awvalid%0d: got %b want 1", i, axi_s.AWVALID); end
            total++; if (axi_s.AWADDR !== 32'h4440) begin bad++; $display("FAIL awstall_awaddr%0d: got %h want 4440", i, axi_s.AWADDR); end
            total++; if (axi_s.AWLEN !== 8'd1) begin bad++; $display("FAIL awstall_awlen%0d: got %0d want 1", i, axi_s.AWLEN); end
            total++; if (axi_s.WVALID !== 1'b0) begin bad++; $display("FAIL awstall_wvalid%0d: got %b want 0", i, axi_s.WVALID); end
            cyc();
        end
        run_burst(32'h0000_4440, 8'd1, 0, 1'b0, 1'b0, 0, 2'b00, 1'b0, fin, rc);
        total++; if (fin !== 1'b1) begin bad++; $display("FAIL awstall_done_seen: got %b want 1", fin); end
        total++; if (wq.size() != 2) begin bad++; $display("FAIL awstall_beats: got %0d want 2", wq.size()); end
        else begin
            total++; if (wq[1] !== 32'h4440_0001) begin bad++; $display("FAIL awstall_data1: got %h want 44400001", wq[1]); end
        end
        total++; if (early_w != 0) begin bad++; $display("FAIL w_before_aw: got %0d want 0", early_w); end
        total++; if (ready_in_done != 0) begin bad++; $display("FAIL ready_during_done: got %0d want 0", ready_in_done); end
    endtask

    task automatic test_slverr();
        bit fin; int rc;
        wq.delete(); lq.delete();
        issue_cmd(32'h0000_5000, 8'd2);
        run_burst(32'h0000_5000, 8'd2, 0, 1'b0, 1'b0, 2, 2'b10, 1'b0, fin, rc);
        total++; if (fin !== 1'b1) begin bad++; $display("FAIL slverr_done_seen: got %b want 1", fin); end
        total++; if (last_resp !== 2'b10) begin bad++; $display("FAIL slverr_resp: got %b want 10", last_resp); end
        total++; if (wq.size() != 3) begin bad++; $display("FAIL slverr_beats: got %0d want 3", wq.size()); end
    endtask

    task automatic test_resp_wait();
        bit fin; int rc;
        wq.delete(); lq.delete();
        issue_cmd(32'h0000_6000, 8'd0);
`ifdef AXI_WR_TIMEOUT_EN
        run_burst(32'h0000_6000, 8'd0, 0, 1'b0, 1'b0, 0, 2'b00, 1'b1, fin, rc);
        total++; if (fin !== 1'b1) begin bad++; $display("FAIL timeout_done_seen: got %b want 1", fin); end
        total++; if (rc != 16) begin bad++; $display("FAIL timeout_resp_cycles: got %0d want 16", rc); end
        total++; if (last_resp !== 2'b10) begin bad++; $display("FAIL timeout_resp: got %b want 10", last_resp); end
`else
        run_burst(32'h0000_6000, 8'd0, 0, 1'b0, 1'b0, 40, 2'b00, 1'b0, fin, rc);
        total++; if (fin !== 1'b1) begin bad++; $display("FAIL bwait_done_seen: got %b want 1", fin); end
        total++; if (rc != 41) begin bad++; $display("FAIL bwait_resp_cycles: got %0d want 41", rc); end
        total++; if (last_resp !== 2'b00) begin bad++; $display("FAIL bwait_resp: got %b want 00", last_resp); end
`endif
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL respwait_busy: got %b want 0", busy); end
    endtask

    task automatic test_reset_mid();
        bit fin; int rc; int d0;
        wq.delete(); lq.delete();
        issue_cmd(32'h0000_7000, 8'd3);
        axi_s.AWREADY = 1'b1;
        axi_s.WREADY  = 1'b1;
        wr_valid      = 1'b1;
        wr_data       = 32'h7000_0000;
        cyc();
        cyc();
        wr_data = 32'h7000_0001;
        #2;
        ARESETn = 1'b0;
        #1;
        d0 = done_cnt;
        total++; if (axi_s.AWVALID !== 1'b0) begin bad++; $display("FAIL mid_awvalid: got %b want 0", axi_s.AWVALID); end
        total++; if (axi_s.WVALID !== 1'b0) begin bad++; $display("FAIL mid_wvalid: got %b want 0", axi_s.WVALID); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy: got %b want 0", busy); end
        idle_inputs();
        @(negedge clk);
        total++; if (axi_s.BREADY !== 1'b0) begin bad++; $display("FAIL mid_bready: got %b want 0", axi_s.BREADY); end
        repeat (3) cyc();
        total++; if (done_cnt != d0) begin bad++; $display("FAIL mid_no_done: got %0d want %0d", done_cnt, d0); end
        total++; if (wq.size() != 1) begin bad++; $display("FAIL mid_beats: got %0d want 1", wq.size()); end
        ARESETn = 1'b1;
        wq.delete(); lq.delete(); d0 = done_cnt;
        issue_cmd(32'h0000_7100, 8'd3);
        run_burst(32'h0000_7100, 8'd3, 0, 1'b0, 1'b0, 0, 2'b00, 1'b0, fin, rc);
        total++; if (fin !== 1'b1) begin bad++; $display("FAIL post_done_seen: got %b want 1", fin); end
        total++; if (wq.size() != 4) begin bad++; $display("FAIL post_beats: got %0d want 4", wq.size()); end
        else begin
            total++; if (wq[3] !== 32'h7100_0003) begin bad++; $display("FAIL post_data3: got %h want 71000003", wq[3]); end
            total++; if (lq[3] !== 1'b1) begin bad++; $display("FAIL post_wlast: got %b want 1", lq[3]); end
        end
        total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL post_done_count: got %0d want 1", done_cnt - d0); end
        total++; if (last_resp !== 2'b00) begin bad++; $display("FAIL post_resp: got %b want 00", last_resp); end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_single();
        test_stalls();
        test_aw_stall();
        test_slverr();
        test_resp_wait();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
